// File: rtl/obi_pkg.sv
// Shared OBI constants: default bus widths and master-ID encoding.
package obi_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  // Master IDs as stored in the in-order response FIFO
  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of 1-bit master IDs, one entry per accepted slave transaction.
module obi_id_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            push_id_i,
  input  logic            pop_i,
  output logic            head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Overflow and underflow requests are dropped rather than corrupting state
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state: write at wptr, read at rptr, pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_id_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Two OBI masters sharing one OBI slave: round-robin address phase with
// wait-state lock, in-order response routing through an ID FIFO.
module obi_arbiter_2to1
  import obi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = OBI_ADDR_W,
  parameter int unsigned DATA_W          = OBI_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  output logic              m0_gnt_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  output logic              m1_gnt_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic            lock_valid_q, lock_valid_d;
  logic            lock_sel_q, lock_sel_d;
  logic            last_q, last_d;   // ID of the most recently granted master
  logic            sel, sel_valid, sel_req;
  logic            handshake, rsp_valid;
  logic            fifo_head, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            unused_count;

  assign unused_count = ^fifo_count;

  // Selection: held while locked, otherwise round-robin; nothing while full
  always_comb begin
    sel_valid = 1'b0;
    sel       = MID_M0;
    if (lock_valid_q) begin
      sel_valid = 1'b1;
      sel       = lock_sel_q;
    end else if (!fifo_full) begin
      case ({m1_req_i, m0_req_i})
        2'b01: begin
          sel_valid = 1'b1;
          sel       = MID_M0;
        end
        2'b10: begin
          sel_valid = 1'b1;
          sel       = MID_M1;
        end
        2'b11: begin
          sel_valid = 1'b1;
          sel       = (last_q == MID_M0) ? MID_M1 : MID_M0;
        end
        default: begin
          sel_valid = 1'b0;
          sel       = MID_M0;
        end
      endcase
    end
  end

  // Address-phase mux from the selected master
  always_comb begin
    if (sel == MID_M1) begin
      sel_req = m1_req_i;
      addr_o  = m1_addr_i;
      we_o    = m1_we_i;
      be_o    = m1_be_i;
      wdata_o = m1_wdata_i;
    end else begin
      sel_req = m0_req_i;
      addr_o  = m0_addr_i;
      we_o    = m0_we_i;
      be_o    = m0_be_i;
      wdata_o = m0_wdata_i;
    end
  end

  // A locked master that drops req yields req_o = 0, so no handshake and the lock falls away
  assign req_o     = !rst_i && !fifo_full && sel_valid && sel_req;
  assign handshake = req_o && gnt_i;
  assign m0_gnt_o  = handshake && (sel == MID_M0);
  assign m1_gnt_o  = handshake && (sel == MID_M1);

  // Responses go to the FIFO head; rvalid_i with nothing outstanding is dropped
  assign rsp_valid   = !rst_i && rvalid_i && !fifo_empty;
  assign m0_rvalid_o = rsp_valid && (fifo_head == MID_M0);
  assign m1_rvalid_o = rsp_valid && (fifo_head == MID_M1);
  assign m0_rdata_o  = rdata_i;
  assign m1_rdata_o  = rdata_i;

  // Next-state for lock and round-robin pointer
  always_comb begin
    lock_valid_d = req_o && !gnt_i;
    lock_sel_d   = lock_valid_d ? sel : lock_sel_q;
    last_d       = handshake ? sel : last_q;
  end

  // State register; last_q resets to M1 so M0 wins the first contention
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_valid_q <= 1'b0;
      lock_sel_q   <= MID_M0;
      last_q       <= MID_M1;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_sel_q   <= lock_sel_d;
      last_q       <= last_d;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (handshake),
    .push_id_i (sel),
    .pop_i     (rsp_valid),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Directed bench for obi_arbiter_2to1 with a queue-based reference model
// checked on every cycle, plus hand-computed spot checks.
module tb_obi_arbiter_2to1;

  localparam int unsigned MAX = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_req, m1_req, m0_gnt, m1_gnt;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_we, m1_we;
  logic [DW/8-1:0] m0_be, m1_be;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          req_o, gnt_i;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic [DW/8-1:0] be_o;
  logic [DW-1:0] wdata_o;
  logic          rvalid_i;
  logic [DW-1:0] rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obi_arbiter_2to1 #(
    .MAX_OUTSTANDING (MAX),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m0_req_i    (m0_req),
    .m0_gnt_o    (m0_gnt),
    .m0_addr_i   (m0_addr),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_wdata_i  (m0_wdata),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_gnt_o    (m1_gnt),
    .m1_addr_i   (m1_addr),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_wdata_i  (m1_wdata),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .addr_o      (addr_o),
    .we_o        (we_o),
    .be_o        (be_o),
    .wdata_o     (wdata_o),
    .rvalid_i    (rvalid_i),
    .rdata_i     (rdata_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit mq[$];         // master IDs of accepted, unanswered transactions, oldest first
  bit last_m = 1'b1; // most recently granted master
  bit lock_v = 1'b0;
  bit lock_m = 1'b0;
  bit have, cand, e_req, e_g0, e_g1, e_rv0, e_rv1;

  always begin
    @(negedge clk);
    have  = 1'b0;
    cand  = 1'b0;
    e_req = 1'b0;
    e_g0  = 1'b0;
    e_g1  = 1'b0;
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    if (!rst_i) begin
      if (lock_v) begin
        have = 1'b1;
        cand = lock_m;
      end else if (mq.size() < MAX) begin
        if (m0_req && m1_req) begin
          have = 1'b1;
          cand = !last_m;
        end else if (m0_req || m1_req) begin
          have = 1'b1;
          cand = m1_req;
        end
      end
      e_req = have && (cand ? m1_req : m0_req);
      e_g0  = e_req && gnt_i && !cand;
      e_g1  = e_req && gnt_i && cand;
      if (rvalid_i && mq.size() > 0) begin
        e_rv0 = !mq[0];
        e_rv1 = mq[0];
      end
    end
    chk("req_o", req_o, e_req);
    chk("m0_gnt", m0_gnt, e_g0);
    chk("m1_gnt", m1_gnt, e_g1);
    chk("m0_rvalid", m0_rvalid, e_rv0);
    chk("m1_rvalid", m1_rvalid, e_rv1);
    if (e_req) begin
      chk("addr_o", addr_o, cand ? m1_addr : m0_addr);
      chk("we_o", we_o, cand ? m1_we : m0_we);
      chk("be_o", be_o, cand ? m1_be : m0_be);
      chk("wdata_o", wdata_o, cand ? m1_wdata : m0_wdata);
    end
    if (e_rv0) chk("m0_rdata", m0_rdata, rdata_i);
    if (e_rv1) chk("m1_rdata", m1_rdata, rdata_i);
    @(posedge clk);
    if (rst_i) begin
      mq.delete();
      last_m = 1'b1;
      lock_v = 1'b0;
    end else begin
      if (e_rv0 || e_rv1) void'(mq.pop_front());
      if (e_req && gnt_i) begin
        mq.push_back(cand);
        last_m = cand;
      end
      lock_v = e_req && !gnt_i;
      lock_m = cand;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic quiet();
    m0_req   = 1'b0;
    m1_req   = 1'b0;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
  endtask

  initial begin
    rst_i    = 1'b1;
    quiet();
    m0_addr  = '0;
    m1_addr  = '0;
    m0_we    = 1'b0;
    m1_we    = 1'b1;
    m0_be    = 4'hF;
    m1_be    = 4'h3;
    m0_wdata = 32'h0;
    m1_wdata = 32'h55;
    rdata_i  = '0;
    cyc();
    cyc();

    // Reset holds all handshake outputs low even with active inputs
    m0_req = 1'b1; m1_req = 1'b1; gnt_i = 1'b1; rvalid_i = 1'b1;
    look();
    chk("rst_req_o", req_o, 1'b0);
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    cyc();
    quiet();
    cyc();
    rst_i = 1'b0;

    // Single master read
    m0_req = 1'b1; m0_addr = 32'h100; gnt_i = 1'b1;
    look();
    chk("single_m0_gnt", m0_gnt, 1'b1);
    chk("single_addr", addr_o, 32'h100);
    chk("single_m1_gnt", m1_gnt, 1'b0);
    cyc();
    quiet();
    rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF;
    look();
    chk("single_m0_rvalid", m0_rvalid, 1'b1);
    chk("single_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("single_m1_rvalid", m1_rvalid, 1'b0);
    cyc();
    quiet();

    // Fresh reset so master 0 wins the first contention
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;

    // Contention: grants alternate m0, m1, m0, m1; responses follow
    m0_addr = 32'h1000; m1_addr = 32'h2000;
    for (int k = 0; k < 5; k++) begin
      m0_req   = (k < 4);
      m1_req   = (k < 4);
      gnt_i    = (k < 4);
      rvalid_i = (k > 0);
      rdata_i  = 32'hA000 + k;
      look();
      chk("rr_m0_gnt", m0_gnt, (k < 4) && (k % 2 == 0));
      chk("rr_m1_gnt", m1_gnt, (k < 4) && (k % 2 == 1));
      chk("rr_m0_rvalid", m0_rvalid, (k == 1) || (k == 3));
      chk("rr_m1_rvalid", m1_rvalid, (k == 2) || (k == 4));
      cyc();
    end
    quiet();

    // Wait-state lock: m1 holds the slave port through 3 wait cycles
    m1_addr = 32'h200; m0_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      m1_req = 1'b1;
      m0_req = (k >= 1);
      gnt_i  = (k == 3);
      look();
      chk("lock_addr", addr_o, 32'h200);
      chk("lock_m1_gnt", m1_gnt, k == 3);
      chk("lock_m0_gnt", m0_gnt, 1'b0);
      cyc();
    end
    m1_req = 1'b0; gnt_i = 1'b1;
    look();
    chk("lock_next_m0_gnt", m0_gnt, 1'b1);
    chk("lock_next_addr", addr_o, 32'h300);
    cyc();
    quiet();
    rvalid_i = 1'b1;
    look();
    chk("lock_rsp_m1", m1_rvalid, 1'b1);
    cyc();
    look();
    chk("lock_rsp_m0", m0_rvalid, 1'b1);
    cyc();
    quiet();

    // Outstanding limit: four accepted, fifth blocked until a pop has been seen
    m0_req = 1'b1; gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m0_addr = 32'h400 + 32'(4 * k);
      look();
      chk("fill_m0_gnt", m0_gnt, 1'b1);
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      rvalid_i = (k == 2);
      look();
      chk("full_req_o", req_o, 1'b0);
      chk("full_m1_gnt", m1_gnt, 1'b0);
      chk("full_pop_m0_rvalid", m0_rvalid, k == 2);
      cyc();
    end
    rvalid_i = 1'b0;
    look();
    chk("after_pop_m1_gnt", m1_gnt, 1'b1);
    cyc();
    quiet();
    rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("drain_m0", m0_rvalid, k < 3);
      chk("drain_m1", m1_rvalid, k == 3);
      cyc();
    end
    quiet();

    // Simultaneous push and pop: [m0,m1] -> [m1,m1]
    m0_req = 1'b1; gnt_i = 1'b1;
    cyc();
    m0_req = 1'b0; m1_req = 1'b1;
    cyc();
    rvalid_i = 1'b1;
    look();
    chk("pp_m1_gnt", m1_gnt, 1'b1);
    chk("pp_m0_rvalid", m0_rvalid, 1'b1);
    chk("pp_m1_rvalid", m1_rvalid, 1'b0);
    cyc();
    rvalid_i = 1'b0; m1_req = 1'b0; m0_req = 1'b1;
    cyc();
    cyc();
    look();
    chk("pp_count2_full", req_o, 1'b0);
    cyc();
    quiet();
    rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("pp_order_m1", m1_rvalid, k < 2);
      chk("pp_order_m0", m0_rvalid, k >= 2);
      cyc();
    end

    // Spurious rvalid on empty FIFO
    look();
    chk("spur_m0_rvalid", m0_rvalid, 1'b0);
    chk("spur_m1_rvalid", m1_rvalid, 1'b0);
    cyc();
    rvalid_i = 1'b0; m0_req = 1'b1; gnt_i = 1'b1;
    cyc();
    quiet();
    rvalid_i = 1'b1;
    look();
    chk("spur_then_m0_rvalid", m0_rvalid, 1'b1);
    cyc();
    quiet();

    // Reset with three outstanding entries
    m1_req = 1'b1; gnt_i = 1'b1;
    cyc();
    cyc();
    cyc();
    rst_i = 1'b1; m0_req = 1'b1; rvalid_i = 1'b1;
    look();
    chk("midrst_req_o", req_o, 1'b0);
    chk("midrst_m1_gnt", m1_gnt, 1'b0);
    chk("midrst_m1_rvalid", m1_rvalid, 1'b0);
    cyc();
    rst_i = 1'b0; rvalid_i = 1'b0;
    look();
    chk("postrst_m0_gnt", m0_gnt, 1'b1);
    chk("postrst_m1_gnt", m1_gnt, 1'b0);
    cyc();
    quiet();
    rvalid_i = 1'b1;
    look();
    chk("postrst_m0_rvalid", m0_rvalid, 1'b1);
    chk("postrst_m1_rvalid", m1_rvalid, 1'b0);
    cyc();
    quiet();

    // Locked master drops req: no handshake, lock released next cycle
    m0_req = 1'b1; m0_addr = 32'h600;
    cyc();
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h700; gnt_i = 1'b1;
    look();
    chk("drop_req_o", req_o, 1'b0);
    chk("drop_m1_gnt", m1_gnt, 1'b0);
    cyc();
    look();
    chk("drop_next_m1_gnt", m1_gnt, 1'b1);
    cyc();
    quiet();
    rvalid_i = 1'b1;
    look();
    chk("drop_rsp_m1", m1_rvalid, 1'b1);
    cyc();
    quiet();
    cyc();
    look();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_arbiter_2to1.md
Name: obi_arbiter_2to1

Overview:
- Shares one OBI slave port between two OBI master ports.
- Round-robin arbitration on the address phase.
- Tracks every accepted request in an in-order ID FIFO so that each rvalid/rdata goes back to the master that issued it.
- Sits between CPU-side masters (e.g. instruction fetch and data/DMA) and a single OBI memory or bridge. That slave may be the OBI side of our Wishbone-to-OBI path.

Parameters:
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered slave transactions; power of 2, at least 2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- m0_req_i  in  1  master 0 request
- m0_gnt_o  out  1  master 0 grant
- m0_addr_i  in  ADDR_W  master 0 address
- m0_we_i  in  1  master 0 write enable
- m0_be_i  in  DATA_W/8  master 0 byte enables
- m0_wdata_i  in  DATA_W  master 0 write data
- m0_rvalid_o  out  1  master 0 response valid
- m0_rdata_o  out  DATA_W  master 0 read data
- m1_req_i ... m1_rdata_o: same set, same directions and widths, for master 1
- req_o  out  1  slave request
- gnt_i  in  1  slave grant
- addr_o  out  ADDR_W  slave address
- we_o  out  1  slave write enable
- be_o  out  DATA_W/8  slave byte enables
- wdata_o  out  DATA_W  slave write data
- rvalid_i  in  1  slave response valid
- rdata_i  in  DATA_W  slave read data

Behaviour:
- Reset (rst_i high, sampled on clk_i):
  - ID FIFO emptied; count = 0.
  - Lock cleared.
  - Round-robin pointer set so master 0 wins the first contention.
  - While rst_i is high, req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o and m1_rvalid_o are forced to 0.
  - rdata outputs are don't-care.
  - Reset mid-transaction drops all in-flight tracking. The slave must be reset together with this block.
- Selection (combinational) is computed only when the block is not locked and the FIFO is not full:
  - Only one master requesting: that master is selected.
  - Both requesting: the master not granted most recently is selected.
  - Neither requesting: no selection; req_o = 0.
- Address-phase path, zero latency:
  - req_o, addr_o, we_o, be_o and wdata_o are muxed from the selected master.
  - gnt_i is routed to the selected master's gnt only. The other master's gnt is 0.
- Lock (OBI address-phase stability):
  - If req_o = 1 and gnt_i = 0 at a clock edge, register lock_valid = 1 and lock_sel = the current selection.
  - While locked, the selection is held at lock_sel regardless of the other master.
  - The lock clears on the cycle gnt_i = 1.
  - A locked master is required by OBI to hold req high. If it drops req anyway, the lock clears the next cycle and no handshake is recorded.
- Handshake (req_o && gnt_i at an edge):
  - Push the selected master ID into the FIFO.
  - Update the round-robin pointer to that master.
- FIFO full (count == MAX_OUTSTANDING):
  - req_o forced to 0 and both gnts 0, so no new handshakes.
  - A lock is never active while full, because full blocks req_o before any wait can start.
  - A pop in the same cycle does not unblock the request until the next cycle (full is registered-count based).
- Response path, zero latency:
  - rvalid_i is routed to the master whose ID is at the FIFO head: m<head>_rvalid_o = rvalid_i && !empty.
  - rdata_i drives both m0_rdata_o and m1_rdata_o.
  - Each rvalid_i pops one entry.
- Simultaneous push and pop: count unchanged; both pointers advance.
- rvalid_i while the FIFO is empty: protocol error. It is ignored: no pop, no underflow, and no master sees rvalid.
- Pointers wrap modulo MAX_OUTSTANDING. The count is clog2(MAX_OUTSTANDING)+1 bits wide.
- Ordering: responses are returned strictly in acceptance order. The block relies on the OBI slave responding in order.

Decomposition:
- Shared package obi_pkg holds:
  - OBI_ADDR_W and OBI_DATA_W default constants.
  - The master-ID encoding constants MID_M0 = 0 and MID_M1 = 1.
- One sub-module, obi_id_fifo:
  - Synchronous FIFO, 1-bit wide, depth MAX_OUTSTANDING.
  - Signals: push, pop, head, full, empty, count.
  - Same clock and synchronous active-high reset as the parent.
- Arbitration, lock and muxing stay in obi_arbiter_2to1.

Test Plan:
- Single master:
  - Stimulus: m0 read to addr 0x100, slave gnt same cycle, rvalid 1 cycle later with rdata 0xDEADBEEF.
  - Required: m0_gnt_o = 1 in cycle 0; m0_rvalid_o = 1 with rdata 0xDEADBEEF in cycle 1; m1_rvalid_o stays 0.
- Contention and round-robin:
  - Stimulus: both masters hold req for 4 cycles; slave always grants and responds next cycle.
  - Required: grants go m0, m1, m0, m1, and responses are routed in that same order.
- Wait-state lock:
  - Stimulus: m1 requests addr 0x200 alone; gnt_i = 0 for 3 cycles while m0 starts requesting in cycle 1.
  - Required: addr_o stays 0x200 and selection stays m1 until gnt; m0 is granted on the next handshake.
- Outstanding limit (MAX_OUTSTANDING = 4):
  - Stimulus: 4 granted requests with no rvalid, then a fifth request.
  - Required: req_o = 0 and both gnts 0 until one rvalid pops; the fifth request is granted the cycle after the pop.
- Simultaneous push and pop:
  - Stimulus: FIFO holds [m0, m1]; in one cycle m1 gets a handshake and rvalid_i = 1.
  - Required: m0_rvalid_o = 1; FIFO then holds [m1, m1]; count stays 2.
- Spurious rvalid and reset:
  - Stimulus 1: rvalid_i = 1 with the FIFO empty. Required: no master rvalid; count stays 0.
  - Stimulus 2: assert rst_i with 3 entries outstanding. Required: next cycle count = 0, all gnt/rvalid outputs 0, and master 0 wins the first post-reset contention.
